health_controller: RTL



---
 rtl/health_pkg.sv | 18 +
 rtl/health_controller_if.sv | 29 ++
 rtl/contact_filter.sv | 35 +++
 rtl/health_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/health_pkg.sv
// Shared types and constants for the player health controller.
// No logic; imported by the interface, the filter and the top.
package health_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam int SRC_W = 3;

  // Counter width able to hold v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/health_controller_if.sv
// Frame/contact inputs and HUD-facing status outputs of the health controller.
// Pure wiring; the slave side is the controller, the master side drives stimulus.
interface health_controller_if #(
  parameter int NUM_SOURCES = 2,
  parameter int LIVES_W     = 2
);
  import health_pkg::*;

  logic                   vsync;
  logic [NUM_SOURCES-1:0] contact;
  logic                   heal;
  logic                   restart;
  logic [LIVES_W-1:0]     lives;
  logic                   player_hurt;
  logic [SRC_W-1:0]       hurt_src;
  logic                   invuln;
  logic                   game_over;

  modport master (
    output vsync, contact, heal, restart,
    input  lives, player_hurt, hurt_src, invuln, game_over
  );

  modport slave (
    input  vsync, contact, heal, restart,
    output lives, player_hurt, hurt_src, invuln, game_over
  );

endinterface

// File: rtl/contact_filter.sv
// Per-source contact tolerance counter; qual is combinational on the tick itself.
// Counter updates only on frame ticks; no backpressure.
module contact_filter #(
  parameter int TOLERANCE = 60,
  parameter int TOL_W     = 6
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic contact,
  input  logic clear,
  output logic qual
);

  logic [TOL_W-1:0] cnt;
  logic             at_limit;

  assign at_limit = (cnt == TOL_W'(TOLERANCE));
  assign qual     = tick & contact & ~clear & at_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      if (!contact || at_limit) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + TOL_W'(1);
      end
    end
  end

endmodule

// File: rtl/health_controller.sv
// Player lives/invulnerability controller: filtered hits, heal, game over, restart.
// Status outputs update one cycle after the causing frame tick; no backpressure.
module health_controller
  import health_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int LIVES_W       = 2,
  parameter int NUM_SOURCES   = 2,
  parameter int TOLERANCE     = 60,
  parameter int INVULN_FRAMES = 90
) (
  input  logic                clk,
  input  logic                reset_n,
  health_controller_if.slave  bus
);

  localparam int TOL_W = clog2_min1(TOLERANCE + 1);
  localparam int INV_W = clog2_min1(INVULN_FRAMES + 1);

  state_t               state_q, state_nxt;
  logic [LIVES_W-1:0]   lives_q, lives_nxt, lives_inc;
  logic [INV_W-1:0]     inv_q, inv_nxt;
  logic [SRC_W-1:0]     src_q, src_nxt, hit_src;
  logic                 hurt_q, hurt_nxt;
  logic                 prev_vsync;
  logic                 tick;
  logic                 filt_clear;
  logic                 hit;
  logic [NUM_SOURCES-1:0] qual;

  assign tick       = bus.vsync & ~prev_vsync;
  assign filt_clear = bus.restart | (state_q != ALIVE);
  assign hit        = |qual;
  assign lives_inc  = (lives_q < LIVES_W'(MAX_LIVES)) ? lives_q + LIVES_W'(1) : lives_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_vsync <= 1'b0;
    end else begin
      prev_vsync <= bus.vsync;
    end
  end

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    contact_filter #(
      .TOLERANCE (TOLERANCE),
      .TOL_W     (TOL_W)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .contact (bus.contact[g]),
      .clear   (filt_clear),
      .qual    (qual[g])
    );
  end

  // Lowest-numbered qualifying source wins.
  always_comb begin
    hit_src = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (qual[i]) hit_src = SRC_W'(i);
    end
  end

  always_comb begin
    state_nxt = state_q;
    lives_nxt = lives_q;
    inv_nxt   = inv_q;
    src_nxt   = src_q;
    hurt_nxt  = 1'b0;
    if (bus.restart) begin
      state_nxt = ALIVE;
      lives_nxt = LIVES_W'(MAX_LIVES);
      inv_nxt   = '0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit) begin
            hurt_nxt = 1'b1;
            src_nxt  = hit_src;
            // Fatal check ignores a coincident heal.
            if (lives_q <= LIVES_W'(1)) begin
              state_nxt = DEAD;
              lives_nxt = '0;
            end else begin
              if (!bus.heal) lives_nxt = lives_q - LIVES_W'(1);
              if (INVULN_FRAMES > 0) begin
                state_nxt = INVULN;
                inv_nxt   = INV_W'(INVULN_FRAMES);
              end
            end
          end else if (bus.heal) begin
            lives_nxt = lives_inc;
          end
        end
        INVULN: begin
          if (bus.heal) lives_nxt = lives_inc;
          if (tick) begin
            if (inv_q <= INV_W'(1)) begin
              inv_nxt   = '0;
              state_nxt = ALIVE;
            end else begin
              inv_nxt = inv_q - INV_W'(1);
            end
          end
        end
        DEAD: begin
          lives_nxt = '0;
        end
        default: begin
          state_nxt = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ALIVE;
      lives_q <= LIVES_W'(MAX_LIVES);
      inv_q   <= '0;
      src_q   <= '0;
      hurt_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      lives_q <= lives_nxt;
      inv_q   <= inv_nxt;
      src_q   <= src_nxt;
      hurt_q  <= hurt_nxt;
    end
  end

  assign bus.lives       = lives_q;
  assign bus.player_hurt = hurt_q;
  assign bus.hurt_src    = src_q;
  assign bus.invuln      = (state_q == INVULN);
  assign bus.game_over   = (state_q == DEAD);

endmodule
